bus_master_ctrl: RTL

BUS_MASTER_CTRL -- requirements
Module: bus_master_ctrl

---
 rtl/bus_master_ctrl_pkg.sv | 18 +
 rtl/bus_master_ctrl_addr_dec.sv | 25 ++
 rtl/bus_master_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/bus_master_ctrl_pkg.sv
// Shared widths, active-low signal levels and FSM state encoding for the
// bus master controller and its address decoder.
package bus_master_ctrl_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  // Bus strobes (as_, we_, cs_, rdy_) are active-low.
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bus_master_ctrl_addr_dec.sv
// Combinational decode of the top log2(SLV_NUM) address bits into a
// one-cold, active-low chip-select vector.
module bus_addr_dec
  import bus_master_ctrl_pkg::*;
#(
  parameter int SLV_NUM = 4
) (
  input  logic [ADDR_W-1:0]  addr,
  output logic [SLV_NUM-1:0] cs_
);

  localparam int SEL_W = $clog2(SLV_NUM);

  logic [SEL_W-1:0] sel;

  assign sel = addr[ADDR_W-1 -: SEL_W];

  always_comb begin
    cs_ = '1;
    for (int unsigned i = 0; i < SLV_NUM; i++) begin
      if (sel == i[SEL_W-1:0]) cs_[i] = ENABLE_;
    end
  end

endmodule

// File: rtl/bus_master_ctrl.sv
// Single-access bus master: IDLE -> BUS -> DONE, all outputs registered.
// Optional rdy_ timeout abort is built when BUS_TIMEOUT_EN is defined.
module bus_master_ctrl
  import bus_master_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16,
  parameter int SLV_NUM     = 4
) (
  input  logic               clk,
  input  logic               reset_,
  input  logic               req,
  input  logic               req_rw,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [DATA_W-1:0]  req_wdata,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [DATA_W-1:0]  rd_data,
  output logic [ADDR_W-1:0]  addr,
  output logic [DATA_W-1:0]  d_out,
  input  logic [DATA_W-1:0]  d_in,
  output logic               as_,
  output logic               we_,
  output logic [SLV_NUM-1:0] cs_,
  input  logic               rdy_
);

  if (SLV_NUM < 2 || SLV_NUM > 4 || (SLV_NUM & (SLV_NUM - 1)) != 0 ||
      TIMEOUT_CYC < 1) begin : g_bad_param
    $error("bus_master_ctrl: unsupported SLV_NUM or TIMEOUT_CYC");
  end

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  d_out_q, d_out_d;
  logic [DATA_W-1:0]  rd_data_q, rd_data_d;
  logic               as_q, as_d;
  logic               we_q, we_d;
  logic [SLV_NUM-1:0] cs_q, cs_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [SLV_NUM-1:0] dec_cs;

`ifdef BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  bus_addr_dec #(
    .SLV_NUM(SLV_NUM)
  ) u_dec (
    .addr(req_addr),
    .cs_ (dec_cs)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    d_out_d   = d_out_q;
    rd_data_d = rd_data_q;
    as_d      = as_q;
    we_d      = we_q;
    cs_d      = cs_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
`ifdef BUS_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d = ST_BUS;
          addr_d  = req_addr;
          d_out_d = req_wdata;
          as_d    = ENABLE_;
          we_d    = req_rw ? ENABLE_ : DISABLE_;
          cs_d    = dec_cs;
`ifdef BUS_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ST_BUS: begin
        if (rdy_ == ENABLE_) begin
          state_d = ST_DONE;
          if (we_q == DISABLE_) rd_data_d = d_in;
          as_d    = DISABLE_;
          we_d    = DISABLE_;
          cs_d    = '1;
          done_d  = 1'b1;
        end
`ifdef BUS_TIMEOUT_EN
        // Abort on the TIMEOUT_CYC-th BUS cycle that still lacks rdy_.
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          state_d = ST_DONE;
          as_d    = DISABLE_;
          we_d    = DISABLE_;
          cs_d    = '1;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      d_out_q   <= '0;
      rd_data_q <= '0;
      as_q      <= DISABLE_;
      we_q      <= DISABLE_;
      cs_q      <= '1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      d_out_q   <= d_out_d;
      rd_data_q <= rd_data_d;
      as_q      <= as_d;
      we_q      <= we_d;
      cs_q      <= cs_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef BUS_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign rd_data = rd_data_q;
  assign addr    = addr_q;
  assign d_out   = d_out_q;
  assign as_     = as_q;
  assign we_     = we_q;
  assign cs_     = cs_q;

endmodule
